// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle for nibble_serial_adder.
// Optional SUB control present only when NSA_SUBTRACT_EN is defined.
interface nibble_serial_adder_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] A1;
  logic [W-1:0] B1;
  logic         CI;
  logic [W-1:0] S1;
  logic         CO;
  logic         OV;
  logic         busy;
  logic         done;
`ifdef NSA_SUBTRACT_EN
  logic         SUB;
`endif

  modport master (
    output start, A1, B1, CI,
    input  S1, CO, OV, busy, done
`ifdef NSA_SUBTRACT_EN
    , output SUB
`endif
  );

  modport slave (
    input  start, A1, B1, CI,
    output S1, CO, OV, busy, done
`ifdef NSA_SUBTRACT_EN
    , input SUB
`endif
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder reusing one 4-bit ripple slice, one nibble per clock.
// Optional feature macro: NSA_SUBTRACT_EN (adds SUB input; A-B via inverted B, carry-in 1).
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  nibble_serial_adder_if.slave bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   a_q, b_q, work_q;
  logic           carry_q;
  logic [IW-1:0]  idx_q;
  logic           sub_in;
  logic           accept, last;
  logic [3:0]     a_nib, b_nib, s_nib;
  logic           s_co;

`ifdef NSA_SUBTRACT_EN
  assign sub_in = bus.SUB;
`else
  assign sub_in = 1'b0;
`endif

  assign accept = (state == IDLE) && bus.start;
  assign last   = (idx_q == IW'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // 4-bit ripple-carry slice on the current nibble
  always_comb begin
    logic c;
    a_nib = a_q[{idx_q, 2'b00} +: 4];
    b_nib = b_q[{idx_q, 2'b00} +: 4];
    c     = carry_q;
    s_nib = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      s_nib[i] = a_nib[i] ^ b_nib[i] ^ c;
      c        = (a_nib[i] & b_nib[i]) | (c & (a_nib[i] ^ b_nib[i]));
    end
    s_co = c;
  end

  // Operand capture, per-nibble accumulation and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      bus.S1  <= '0;
      bus.CO  <= 1'b0;
      bus.OV  <= 1'b0;
    end else if (accept) begin
      // Subtraction folds into the add path: B stored inverted, carry-in forced to 1
      a_q     <= bus.A1;
      b_q     <= sub_in ? ~bus.B1 : bus.B1;
      carry_q <= sub_in ? 1'b1 : bus.CI;
      idx_q   <= '0;
    end else if (state == RUN) begin
      work_q[{idx_q, 2'b00} +: 4] <= s_nib;
      carry_q <= s_co;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        bus.S1 <= {s_nib, work_q[W-5:0]};
        bus.CO <= s_co;
        bus.OV <= (a_q[W-1] == b_q[W-1]) && (s_nib[3] != a_q[W-1]);
      end
    end
  end
endmodule
